// File: rtl/glyph_div3_sched.sv
// glyph_div3_sched: shares one divide-by-3 datapath between the H (column) and
// V (row) coordinate requesters through a two-stage valid/ready pipeline.
//   Stage A: operand register feeding the div3 datapath.
//   Stage B: result register driving the out_* port.
// Build option: define GLYPH_DIV3_SCHED_RR_EN for round-robin arbitration
// seeded by FIRST_SRC. Left undefined, H has fixed priority and V is served
// only in cycles where H is idle.
module glyph_div3_sched #(
    parameter bit FIRST_SRC = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_valid,
    input  logic [6:0] h_value,
    output logic       h_ready,
    input  logic       v_valid,
    input  logic [6:0] v_value,
    output logic       v_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_src,
    output logic [5:0] out_quot,
    output logic [1:0] out_rem,
    output logic       busy
);

    // Stage A: operand register
    logic       a_valid;
    logic       a_src;
    logic [6:0] a_value;

    // Stage B: result register
    logic       b_valid;
    logic       b_src;
    logic [5:0] b_quot;
    logic [1:0] b_rem;

    logic        b_free;
    logic        a_free;
    logic        grant_h;
    logic        grant_v;
    logic        accept;
    logic [12:0] prod;
    logic [5:0]  quot;
    logic [7:0]  rem_wide;

`ifdef GLYPH_DIV3_SCHED_RR_EN
    logic pri;  // source preferred on the next contended cycle (0 = H, 1 = V)
`endif

    // div3 datapath: floor(x*43/128) equals floor(x/3) for every x in 0..127
    always_comb begin
        prod     = {6'd0, a_value} * 13'd43;
        quot     = prod[12:7];
        rem_wide = {1'b0, a_value} - {1'b0, quot, 1'b0} - {2'b00, quot};
    end

    // Pipeline advance conditions and arbitration
    always_comb begin
        b_free = !b_valid || out_ready;
        a_free = !a_valid || b_free;
`ifdef GLYPH_DIV3_SCHED_RR_EN
        grant_v = v_valid && (!h_valid || pri);
        grant_h = h_valid && (!v_valid || !pri);
`else
        grant_h = h_valid;
        grant_v = v_valid && !h_valid;
`endif
        h_ready = a_free && grant_h;
        v_ready = a_free && grant_v;
        accept  = h_ready || v_ready;
    end

    // Pipeline registers; reset discards any in-flight entries at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_src   <= 1'b0;
            a_value <= 7'd0;
            b_valid <= 1'b0;
            b_src   <= 1'b0;
            b_quot  <= 6'd0;
            b_rem   <= 2'd0;
`ifdef GLYPH_DIV3_SCHED_RR_EN
            pri     <= FIRST_SRC;
`endif
        end else begin
            if (b_free) begin
                b_valid <= a_valid;
                if (a_valid) begin
                    b_src  <= a_src;
                    b_quot <= quot;
                    b_rem  <= rem_wide[1:0];
                end
            end
            if (a_free) begin
                a_valid <= accept;
                if (accept) begin
                    a_src   <= grant_v;
                    a_value <= grant_v ? v_value : h_value;
                end
            end
`ifdef GLYPH_DIV3_SCHED_RR_EN
            // Pointer moves only when the grant is actually taken
            if (accept) begin
                pri <= !grant_v;
            end
`endif
        end
    end

    // Result port mirrors stage B
    always_comb begin
        out_valid = b_valid;
        out_src   = b_src;
        out_quot  = b_quot;
        out_rem   = b_rem;
        busy      = a_valid || b_valid;
    end

endmodule

// File: tb/tb_glyph_div3_sched.sv
// Directed self-checking bench for glyph_div3_sched (FIRST_SRC = 0).
// Inputs change just after the falling edge; outputs are checked 1 time unit
// later, well away from the rising edge.
module tb_glyph_div3_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       h_valid, v_valid, out_ready;
    logic [6:0] h_value, v_value;
    logic       h_ready, v_ready, out_valid, out_src, busy;
    logic [5:0] out_quot;
    logic [1:0] out_rem;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef GLYPH_DIV3_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    glyph_div3_sched #(.FIRST_SRC(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_valid   (h_valid),
        .h_value   (h_value),
        .h_ready   (h_ready),
        .v_valid   (v_valid),
        .v_value   (v_value),
        .v_ready   (v_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic src, input int q, input int r);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".src"},   32'(out_src),   32'(src));
        chk({tag, ".quot"},  32'(out_quot),  32'(q));
        chk({tag, ".rem"},   32'(out_rem),   32'(r));
    endtask

    task automatic edge_drive();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic exp_src;
        int   x;

        rst_n = 1'b0; h_valid = 1'b0; v_valid = 1'b0; out_ready = 1'b1;
        h_value = 7'd0; v_value = 7'd0;

        // Reset state
        #3;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy",      32'(busy),      32'd0);
        chk("rst.out_src",   32'(out_src),   32'd0);
        chk("rst.out_quot",  32'(out_quot),  32'd0);
        chk("rst.out_rem",   32'(out_rem),   32'd0);
        edge_drive();
        rst_n = 1'b1;

        // Single H request of 127
        edge_drive();
        h_valid = 1'b1; h_value = 7'd127; #1;
        chk("single.h_ready", 32'(h_ready), 32'd1);
        edge_drive();
        h_valid = 1'b0; #1;
        chk("single.lat_valid", 32'(out_valid), 32'd0);
        chk("single.lat_busy",  32'(busy),      32'd1);
        edge_drive(); #1;
        chk_out("single", 1'b0, 42, 1);
        edge_drive(); #1;
        chk("single.drained_valid", 32'(out_valid), 32'd0);
        chk("single.drained_busy",  32'(busy),      32'd0);

        // Back-to-back sweep: V 0..127 then H 0..127, one result per cycle
        for (int k = 0; k < 258; k++) begin
            edge_drive();
            h_valid = (k >= 128 && k < 256);
            v_valid = (k < 128);
            h_value = 7'(k);
            v_value = 7'(k);
            #1;
            if (k < 256) chk("sweep.ready", 32'(k < 128 ? v_ready : h_ready), 32'd1);
            if (k >= 2) begin
                x = (k - 2) % 128;
                chk_out("sweep", (k - 2) < 128, x / 3, x % 3);
            end
        end
        edge_drive(); #1;
        chk("sweep.end_valid", 32'(out_valid), 32'd0);

        // Continuous contention H=5, V=6 from a freshly reset pointer
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            edge_drive();
            h_valid = 1'b1; h_value = 7'd5;
            v_valid = 1'b1; v_value = 7'd6;
            #1;
            exp_src = RR && (k % 2 == 1);
            chk("cont.h_ready", 32'(h_ready), 32'(!exp_src));
            chk("cont.v_ready", 32'(v_ready), 32'(exp_src));
            if (k >= 2) begin
                exp_src = RR && ((k - 2) % 2 == 1);
                chk_out("cont", exp_src, exp_src ? 2 : 1, exp_src ? 0 : 2);
            end
        end
        edge_drive();
        h_valid = 1'b0; v_valid = 1'b0;
        edge_drive();
        edge_drive(); #1;
        chk("cont.drained", 32'(busy), 32'd0);

        // Backpressure: H 10..13 with the consumer stalled for three cycles
        edge_drive();
        h_valid = 1'b1; h_value = 7'd10; #1;
        chk("bp.acc10", 32'(h_ready), 32'd1);
        edge_drive();
        h_value = 7'd11; out_ready = 1'b0; #1;
        chk("bp.acc11", 32'(h_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            edge_drive();
            h_value = 7'd12; #1;
            chk("bp.stall_ready", 32'(h_ready), 32'd0);
            chk("bp.stall_busy",  32'(busy),    32'd1);
            chk_out("bp.stall", 1'b0, 3, 1);
        end
        edge_drive();
        out_ready = 1'b1; #1;
        chk("bp.release_ready", 32'(h_ready), 32'd1);
        chk_out("bp.r10", 1'b0, 3, 1);
        edge_drive();
        h_value = 7'd13; #1;
        chk_out("bp.r11", 1'b0, 3, 2);
        edge_drive();
        h_valid = 1'b0; #1;
        chk_out("bp.r12", 1'b0, 4, 0);
        edge_drive(); #1;
        chk_out("bp.r13", 1'b0, 4, 1);
        edge_drive(); #1;
        chk("bp.end_valid", 32'(out_valid), 32'd0);

        // Contention under stall: pointer holds until a grant is taken
        pulse_reset();
        edge_drive();
        h_valid = 1'b1; h_value = 7'd5; v_valid = 1'b1; v_value = 7'd6;
        out_ready = 1'b0; #1;
        chk("cs.first_h", 32'(h_ready), 32'd1);
        edge_drive(); #1;
        chk("cs.second_v", 32'(v_ready), 32'(RR));
        for (int k = 0; k < 2; k++) begin
            edge_drive(); #1;
            chk("cs.stall_h", 32'(h_ready), 32'd0);
            chk("cs.stall_v", 32'(v_ready), 32'd0);
        end
        edge_drive();
        out_ready = 1'b1; #1;
        chk("cs.release_h", 32'(h_ready), 32'd1);
        chk("cs.release_v", 32'(v_ready), 32'd0);
        chk_out("cs.o0", 1'b0, 1, 2);
        edge_drive();
        h_valid = 1'b0; v_valid = 1'b0; #1;
        chk_out("cs.o1", RR, RR ? 2 : 1, RR ? 0 : 2);
        edge_drive(); #1;
        chk_out("cs.o2", 1'b0, 1, 2);
        edge_drive(); #1;
        chk("cs.end_valid", 32'(out_valid), 32'd0);

        // Reset with both stages full
        edge_drive();
        h_valid = 1'b1; h_value = 7'd10; out_ready = 1'b0;
        edge_drive();
        h_value = 7'd11;
        edge_drive();
        h_valid = 1'b0; #1;
        chk("rm.full_busy",  32'(busy),      32'd1);
        chk("rm.full_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0; #1;
        chk("rm.async_valid", 32'(out_valid), 32'd0);
        chk("rm.async_busy",  32'(busy),      32'd0);
        edge_drive();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            edge_drive(); #1;
            chk("rm.no_stale", 32'(out_valid), 32'd0);
        end
        edge_drive();
        h_valid = 1'b1; v_valid = 1'b1; #1;
        chk("rm.first_h", 32'(h_ready), 32'd1);
        chk("rm.first_v", 32'(v_ready), 32'd0);
        edge_drive();
        h_valid = 1'b0; v_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/glyph_div3_sched.md
# glyph_div3_sched

Shared-divider scheduler for the glyph renderer. It arbitrates between a horizontal (column) and a vertical (row) requester that both need a 7-bit coordinate divided by 3. It time-multiplexes one instance of the combinational `div3` datapath, and returns quotient, remainder and source tag through a two-stage valid/ready pipeline. It sits between the VGA timing/coordinate logic and the glyph ROM address generator.

## Interface
- `FIRST_SRC`, default 0: source given priority on the first contended cycle after reset (0 = H, 1 = V).
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `h_valid` in 1: H request valid.
- `h_value` in 7: H dividend, 0..127.
- `h_ready` out 1: H request accepted this cycle when `h_valid & h_ready`.
- `v_valid` in 1: V request valid.
- `v_value` in 7: V dividend, 0..127.
- `v_ready` out 1: V request accepted this cycle when `v_valid & v_ready`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result when `out_valid & out_ready`.
- `out_src` out 1: 0 = H, 1 = V.
- `out_quot` out 6: floor(value/3), range 0..42.
- `out_rem` out 2: value − 3·quot, range 0..2.
- `busy` out 1: either pipeline stage holds a valid entry.

## Operation
- Stage A (operand register) holds `a_valid`, `a_src` and `a_value[6:0]`. The single `div3` instance is driven from `a_value`.
- Stage B (result register) holds `b_valid`, `b_src`, `b_quot` and `b_rem`.
- Outputs: `out_*` = stage B.
- Remainder: `b_rem <= a_value − {quot,1'b0} − quot`. Compute it at 8 bits and truncate to 2; the upper bits are zero by construction.
- Advance conditions:
  - `b_free = !b_valid | out_ready`.
  - `a_free = !a_valid | b_free`.
  - A moves to B when `a_valid & b_free`.
  - A loads a granted request when `a_free`.
- Grant, round-robin with pointer `pri` (the source preferred next). `pri` resets to `FIRST_SRC`.
  - Only one source valid: that source is granted.
  - Both valid: source `pri` is granted.
  - `pri <= ~granted_src` only on an accepted transfer. Unaccepted grants leave `pri` unchanged.
- Ready generation: `h_ready = a_free & grant_h`, `v_ready = a_free & grant_v`. They are never both 1.
  - Ready may depend combinationally on both valids and on `out_ready`.
  - Valids must not depend on ready.
- Ordering: results leave in acceptance order. There is no reordering and no drop.
- Throughput: one result per cycle while `out_ready` is held high.

## Timing
- Latency: a request accepted at edge N gives `out_valid` = 1 after edge N+1 (two register stages). The result is visible in cycle N+1 through N+2.
- Backpressure: with `out_ready` = 0, at most two entries are held (A and B). Both `*_ready` go 0 once A is full and B is stalled. All held data is stable until accepted.
- Simultaneous events: B drains and A refills in the same cycle with no bubble.
- A valid request with ready low must be held stable by the requester (standard valid/ready).
- Reset values: `a_valid` = `b_valid` = 0; `out_valid` = 0; `busy` = 0; `out_src` = 0; `out_quot` = 0; `out_rem` = 0; `pri` = `FIRST_SRC`.
  - `h_ready`/`v_ready` follow the combinational rule, so they are 1 for a valid source while held in reset-released empty state.
- Reset asserted mid-operation:
  - All in-flight entries are discarded immediately and asynchronously.
  - Accepted-but-unreturned requests produce no result.
  - `pri` returns to `FIRST_SRC`.

## Configuration
- `GLYPH_DIV3_SCHED_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority. H always wins when both are valid. `pri` and `FIRST_SRC` have no effect; V is served only in cycles with `h_valid` = 0.

## Test plan
- Single H request 127, `out_ready` = 1 → two cycles later `out_valid` = 1, `out_src` = 0, `out_quot` = 42, `out_rem` = 1. `busy` is low one cycle after the result is accepted.
- Exhaustive sweep 0..127 on V, then on H, streamed back-to-back → one result per cycle; each result has quot = floor(x/3) and rem = x mod 3; no gaps.
- Both valid continuously, H = 5, V = 6, RR enabled, `FIRST_SRC` = 0 → `out_src` sequence 0,1,0,1…; H results are (1,2) and V results are (2,0). With the macro undefined → `out_src` is always 0 and `v_ready` is always 0.
- Stream of H = 10, 11, 12, 13 with `out_ready` low for cycles 2–5 → A and B fill, `h_ready` = 0 while stalled, outputs held stable. On release the results come out in order, (3,1),(3,2),(4,0),(4,1), with none lost or duplicated.
- Contention with `out_ready` stalled → `pri` does not advance while the grant is unaccepted. The first accepted source after release is the `pri` source.
- `rst_n` pulsed low with both stages full → `out_valid` and `busy` drop asynchronously during reset. No stale result appears after release. The next contended grant goes to `FIRST_SRC`.
